// File: rtl/div4_pkg.sv
// Shared types and constants for the 4-bit sequential divider and its subtractor.
package div4_pkg;

    localparam int unsigned        DIV_W      = 4;
    localparam logic [1:0]         COUNT_INIT = 2'd3;
    localparam logic [DIV_W-1:0]   DBZ_QUOT   = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/sub4_borrow.sv
// 4-bit ripple-borrow subtractor: diff = a - b - bin, bout set on underflow.
module sub4_borrow
    import div4_pkg::*;
(
    input  logic [DIV_W-1:0] a,
    input  logic [DIV_W-1:0] b,
    input  logic             bin,
    output logic [DIV_W-1:0] diff,
    output logic             bout
);

    logic [DIV_W:0] brw;

    always_comb begin
        brw    = '0;
        brw[0] = bin;
        diff   = '0;
        for (int unsigned i = 0; i < DIV_W; i++) begin
            diff[i]  = a[i] ^ b[i] ^ brw[i];
            brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
        end
        bout = brw[DIV_W];
    end

endmodule

// File: rtl/seq_div4.sv
// Sequential 4-bit restoring divider: one trial subtraction per clock, MSB first,
// with registered results, a one-cycle done pulse and divide-by-zero flagging.
module seq_div4
    import div4_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    state_t           state;
    logic [1:0]       count;
    logic [DIV_W-1:0] dvd_q;
    logic [DIV_W-1:0] dvs_q;
    logic [DIV_W-1:0] rem_q;
    logic [DIV_W-1:0] quo_q;

    logic [DIV_W:0]   trial;
    logic [DIV_W-1:0] diff;
    logic             bout;
    logic             step_ok;
    logic [DIV_W-1:0] rem_next;
    logic [DIV_W-1:0] quo_next;

    always_comb begin
        trial = {rem_q, dvd_q[count]};
    end

    sub4_borrow u_sub (
        .a    (trial[DIV_W-1:0]),
        .b    (dvs_q),
        .bin  (1'b0),
        .diff (diff),
        .bout (bout)
    );

    // A set trial MSB means the shifted remainder already exceeds any 4-bit divisor.
    always_comb begin
        step_ok         = trial[DIV_W] | ~bout;
        rem_next        = step_ok ? diff : trial[DIV_W-1:0];
        quo_next        = quo_q;
        quo_next[count] = step_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_q <= dividend;
                        dvs_q <= divisor;
                        rem_q <= '0;
                        quo_q <= '0;
                        count <= COUNT_INIT;
                        if (divisor == '0) begin
                            quotient    <= DBZ_QUOT;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    if (count == '0) begin
                        quotient    <= quo_next;
                        remainder   <= rem_next;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        count <= count - 2'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
